mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the MIPS multicycle datapath. Sequences each instruction through a Moore FSM, latches opcode/funct from the memory output during fetch, decodes ALU operations, and drives every datapath control input. Sits directly upstream of the datapath: consumes its `ins_out` and `zeroFlag`, and produces its control vector.

## Interface
Parameters: none.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ins` in 32: memory read data, connected to datapath `ins_out`.
- `zeroFlag` in 1: ALU zero result.
- `PCEn` out 1: PC register enable.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction register enable.
- `RegDst` out 1: write-register select; 0 = rt, 1 = rd.
- `MemtoReg` out 1: write-data select; 0 = ALUOut, 1 = data register.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUControl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PCSrc` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `state_out` out 4: current state encoding, for debug and verification.

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12–15 are unreachable and return to FETCH on the next edge.
- Internal `op_q[5:0]` and `funct_q[5:0]` load `ins[31:26]` and `ins[5:0]` on the FETCH edge only. `ins` is raw memory output, so it is not valid after FETCH. All decoding uses `op_q` and `funct_q`.
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR for lw (100011) or sw (101011).
  - DECODE → EXECUTE for R-type (000000).
  - DECODE → BRANCH for beq (000100).
  - DECODE → ADDIEXEC for addi (001000).
  - DECODE → JUMP for j (000010).
  - DECODE → FETCH for any other opcode (no-op).
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB.
  - EXECUTE → ALUWB.
  - ADDIEXEC → ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP → FETCH.
- Moore outputs per state. Any output not listed for a state is 0.
  - FETCH: IorD 0, ALUSrcA 0, ALUSrcB 01, ALUOp add, PCSrc 00, IRWrite 1, PCWrite 1.
  - DECODE: ALUSrcA 0, ALUSrcB 11, ALUOp add.
  - MEMADR: ALUSrcA 1, ALUSrcB 10, ALUOp add.
  - MEMRD: IorD 1.
  - MEMWB: MemtoReg 1, RegWrite 1.
  - MEMWR: IorD 1, MemWrite 1.
  - EXECUTE: ALUSrcA 1, ALUSrcB 00, ALUOp funct.
  - ALUWB: RegDst 1, RegWrite 1.
  - BRANCH: ALUSrcA 1, ALUSrcB 00, ALUOp sub, PCSrc 01, Branch 1.
  - ADDIEXEC: ALUSrcA 1, ALUSrcB 10, ALUOp add.
  - ADDIWB: RegWrite 1.
  - JUMP: PCSrc 10, PCWrite 1.
- `PCEn = PCWrite | (Branch & zeroFlag)`. This is the only combinational path from an input to an output.
- ALU decode:
  - ALUOp add → 010; ALUOp sub → 110.
  - ALUOp funct:
    - 100000 → 010
    - 100010 → 110
    - 100100 → 000
    - 100101 → 001
    - 101010 → 111
    - any other funct → 010. ALUWB still writes the register file.

## Timing
- Reset asserted: state = FETCH and `op_q`/`funct_q` = 0 immediately. Outputs therefore show FETCH values (IRWrite 1, PCEn 1, ALUSrcB 01, all others 0).
- Reset asserted mid-instruction aborts it; no further write enables are asserted.
- Reset deasserted: the first rising edge performs the FETCH update.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unrecognised opcode 2.
- PCEn in BRANCH follows `zeroFlag` within the same cycle. No registered delay.

## Configuration
- `MC_CTRL_BNE_EN` defined: opcode 000101 (bne) goes DECODE → BRANCH. In that case `PCEn = PCWrite | (Branch & (zeroFlag ^ is_bne))`, where `is_bne = (op_q == 000101)`.
- `MC_CTRL_BNE_EN` undefined: 000101 is an unrecognised opcode (DECODE → FETCH), and PCEn uses `zeroFlag` unmodified.

## Test plan
- Hold reset low for 3 cycles, then release → `state_out` = 0, IRWrite = 1, PCEn = 1, ALUSrcB = 01 during reset; `state_out` = 1 after the first edge.
- `ins` = 0x8C080004 (lw) at FETCH, then `ins` changed to 0xFFFFFFFF → `state_out` sequence 0,1,2,3,4,0; RegWrite = 1 and MemtoReg = 1 only in state 4.
- `ins` = 0x012A402A (slt) → states 0,1,6,7,0; ALUControl = 111 in state 6; RegDst = 1 and RegWrite = 1 in state 7.
- `ins` = 0x11090003 (beq) with `zeroFlag` = 1, then repeated with `zeroFlag` = 0 → PCEn = 1 then 0 in state 8; PCSrc = 01 in both runs.
- `ins` = 0x08000010 (j) → states 0,1,11,0 with PCSrc = 10 and PCEn = 1 in state 11. `ins` = 0xFC000000 (op 111111) → states 0,1,0 with no write enable asserted in state 1.
- `ins` = 0x15090003 (bne), `zeroFlag` = 0 → with `MC_CTRL_BNE_EN`: states 0,1,8 and PCEn = 1; without it: states 0,1,0.

Source files
------------

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Moore-style control unit for the MIPS multicycle datapath. The FSM steps each
// instruction through fetch/decode/execute/memory/writeback states. Opcode and
// funct are latched from the raw memory output during FETCH. Every datapath
// control signal is decoded from the current state.
//
// Ports
//   clk        in  1  rising-edge clock
//   reset      in  1  asynchronous, active-low reset
//   ins        in  32 memory read data (datapath ins_out)
//   zeroFlag   in  1  ALU zero result
//   PCEn       out 1  PC enable = PCWrite | (Branch & zero term)
//   IorD       out 1  memory address select (0 PC, 1 ALUOut)
//   MemWrite   out 1  memory write enable
//   IRWrite    out 1  instruction register enable
//   RegDst     out 1  write-register select (0 rt, 1 rd)
//   MemtoReg   out 1  write-data select (0 ALUOut, 1 data register)
//   RegWrite   out 1  register file write enable
//   ALUSrcA    out 1  0 PC, 1 A
//   ALUSrcB    out 2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//   ALUControl out 3  010 add, 110 sub, 000 and, 001 or, 111 slt
//   PCSrc      out 2  00 ALUResult, 01 ALUOut, 10 jump target
//   state_out  out 4  current state code
//
// Build option
//   MC_CTRL_BNE_EN : when defined, bne (000101) shares the BRANCH state and
//                    the branch condition becomes zeroFlag ^ is_bne.
// -----------------------------------------------------------------------------
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins,
    input  logic        zeroFlag,
    output logic        PCEn,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  PCSrc,
    output logic [3:0]  state_out
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_op;
    logic [5:0]  r_funct;
    aluop_t      w_aluop;
    logic        w_pcwrite;
    logic        w_branch;
    logic        w_zero_eff;
    logic        w_unused_ins;

    // Only opcode and funct fields matter to control; the rest is ignored.
    assign w_unused_ins = ^ins[25:6];

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode/funct capture: memory output is only the instruction during FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op    <= 6'd0;
            r_funct <= 6'd0;
        end else if (r_state == S_FETCH) begin
            r_op    <= ins[31:26];
            r_funct <= ins[5:0];
        end else begin
            r_op    <= r_op;
            r_funct <= r_funct;
        end
    end

    // Next-state logic; unused codes 12-15 fall back to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (r_op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       w_next = S_BRANCH;
`endif
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (r_op == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_MEMRD;
                end
            end
            S_MEMRD:    w_next = S_MEMWB;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ADDIEXEC: w_next = S_ADDIWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Moore output decode; everything not named for a state stays 0.
    always_comb begin
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSrc     = 2'b00;
        w_aluop   = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b01;
                IRWrite   = 1'b1;
                w_pcwrite = 1'b1;
            end
            S_DECODE:   ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD:    IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                w_aluop  = ALUOP_SUB;
                PCSrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB:   RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: begin
                w_pcwrite = 1'b0;
            end
        endcase
    end

    // ALU decode; unknown funct codes default to add.
    always_comb begin
        ALUControl = 3'b010;
        case (w_aluop)
            ALUOP_ADD: ALUControl = 3'b010;
            ALUOP_SUB: ALUControl = 3'b110;
            ALUOP_FUNCT: begin
                case (r_funct)
                    6'b100000: ALUControl = 3'b010;
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default:   ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase
    end

`ifdef MC_CTRL_BNE_EN
    // bne inverts the sense of the zero test inside the shared BRANCH state.
    assign w_zero_eff = zeroFlag ^ (r_op == OP_BNE);
`else
    assign w_zero_eff = zeroFlag;
`endif

    // The only input-to-output combinational path: branch resolves same cycle.
    assign PCEn      = w_pcwrite | (w_branch & w_zero_eff);
    assign state_out = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
// Self-checking bench for mc_controller: reset behaviour, a table of directed
// instructions with their expected state paths, a mid-instruction reset, and
// random instructions checked against a behavioural model of the control unit.
// -----------------------------------------------------------------------------
module tb_mc_controller;

    logic        clk;
    logic        reset;
    logic [31:0] ins;
    logic        zeroFlag;
    logic        PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  PCSrc;
    logic [3:0]  state_out;

    int n_checks = 0;
    int n_errors = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .ins        (ins),
        .zeroFlag   (zeroFlag),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .PCSrc      (PCSrc),
        .state_out  (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vector: instruction, zero mode (0/1 constant, 2 random per
    // cycle), expected number of states and the state path (nibble k = step k).
    typedef struct {
        logic [31:0] instr;
        int          zmode;
        int          n;
        logic [23:0] path;
        string       nm;
    } vec_t;

    vec_t vecs[8];

    // Reference: state path an instruction walks, built from cycle rules.
    function automatic int model_path(input logic [5:0] op, output logic [23:0] p);
        int q[$];
        q = {0, 1};
        case (op)
            6'b100011: q = {q, 2, 3, 4};
            6'b101011: q = {q, 2, 5};
            6'b000000: q = {q, 6, 7};
            6'b000100: q.push_back(8);
            6'b001000: q = {q, 9, 10};
            6'b000010: q.push_back(11);
`ifdef MC_CTRL_BNE_EN
            6'b000101: q.push_back(8);
`endif
            default: ;
        endcase
        p = 24'h0;
        foreach (q[i]) p[4*i +: 4] = 4'(q[i]);
        return q.size();
    endfunction

    function automatic logic [2:0] model_alu_funct(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Expected {PCEn,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
    //           ALUSrcB,ALUControl,PCSrc} for a given state.
    function automatic logic [14:0] model_out(input int st, input logic [5:0] op,
                                              input logic [5:0] fn, input logic z);
        logic pcen, iord, mw, irw, rd, m2r, rw, sa, brz;
        logic [1:0] sb, ps;
        logic [2:0] alu;
        {pcen, iord, mw, irw, rd, m2r, rw, sa} = 8'h00;
        sb = 2'b00; ps = 2'b00; alu = 3'b000;
`ifdef MC_CTRL_BNE_EN
        brz = z ^ (op == 6'b000101);
`else
        brz = z;
`endif
        case (st)
            0:  begin sb = 2'b01; alu = 3'b010; irw = 1'b1; pcen = 1'b1; end
            1:  begin sb = 2'b11; alu = 3'b010; end
            2:  begin sa = 1'b1; sb = 2'b10; alu = 3'b010; end
            3:  iord = 1'b1;
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin iord = 1'b1; mw = 1'b1; end
            6:  begin sa = 1'b1; alu = model_alu_funct(fn); end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin sa = 1'b1; alu = 3'b110; ps = 2'b01; pcen = brz; end
            9:  begin sa = 1'b1; sb = 2'b10; alu = 3'b010; end
            10: rw = 1'b1;
            11: begin ps = 2'b10; pcen = 1'b1; end
            default: ;
        endcase
        return {pcen, iord, mw, irw, rd, m2r, rw, sa, sb, alu, ps};
    endfunction

    // ALUControl is only defined in states that drive an ALU operation.
    function automatic logic [14:0] model_mask(input int st);
        if (st == 0 || st == 1 || st == 2 || st == 6 || st == 8 || st == 9)
            return 15'h7FFF;
        else
            return 15'h7FE3;
    endfunction

    function automatic logic [14:0] dut_out();
        return {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUControl, PCSrc};
    endfunction

    task automatic chk_state(input string nm, input logic [3:0] exp);
        n_checks++;
        if (state_out !== exp) begin
            n_errors++;
            $display("FAIL %s state: got %0d expected %0d", nm, state_out, exp);
        end
    endtask

    task automatic chk_outs(input string nm, input int st, input logic [5:0] op,
                            input logic [5:0] fn);
        logic [14:0] e, m;
        e = model_out(st, op, fn, zeroFlag);
        m = model_mask(st);
        n_checks++;
        if ((dut_out() & m) !== (e & m)) begin
            n_errors++;
            $display("FAIL %s outs st=%0d: got %h expected %h (mask %h)",
                     nm, st, dut_out() & m, e & m, m);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH, checking every state and its outputs.
    task automatic run_instr(input logic [31:0] instr, input int zmode, input int n,
                             input logic [23:0] path, input string nm);
        logic [5:0] op, fn;
        logic [3:0] es;
        op = instr[31:26];
        fn = instr[5:0];
        for (int k = 0; k < n; k++) begin
            es = path[4*k +: 4];
            ins = (k == 0) ? instr : $urandom;
            zeroFlag = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            #1;
            chk_state(nm, es);
            chk_outs(nm, int'(es), op, fn);
            step();
        end
        chk_state({nm, "_ret"}, 4'd0);
    endtask

    initial begin
        logic [23:0] p;
        logic [5:0]  op, fn;
        logic [19:0] mid;
        int          n;

        vecs[0] = '{32'h8C080004, 0, 5, 24'h043210, "lw"};
        vecs[1] = '{32'hAD280004, 0, 4, 24'h005210, "sw"};
        vecs[2] = '{32'h012A402A, 0, 4, 24'h007610, "slt"};
        vecs[3] = '{32'h11090003, 1, 3, 24'h000810, "beq_z1"};
        vecs[4] = '{32'h11090003, 0, 3, 24'h000810, "beq_z0"};
        vecs[5] = '{32'h08000010, 0, 3, 24'h000B10, "j"};
        vecs[6] = '{32'hFC000000, 0, 2, 24'h000010, "badop"};
`ifdef MC_CTRL_BNE_EN
        vecs[7] = '{32'h15090003, 0, 3, 24'h000810, "bne"};
`else
        vecs[7] = '{32'h15090003, 0, 2, 24'h000010, "bne"};
`endif

        // Reset held for three edges: FETCH outputs visible throughout.
        reset = 1'b0;
        ins = 32'hFC000000;
        zeroFlag = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_state("rst", 4'd0);
            chk_outs("rst", 0, 6'd0, 6'd0);
            step();
        end
        reset = 1'b1;
        #1;
        chk_state("rel", 4'd0);
        step();
        chk_state("rel_first_edge", 4'd1);
        step();
        chk_state("rel_back", 4'd0);

        // Directed table.
        foreach (vecs[i])
            run_instr(vecs[i].instr, vecs[i].zmode, vecs[i].n, vecs[i].path, vecs[i].nm);

        // Reset in the middle of lw (at MEMRD) aborts it.
        ins = 32'h8C080004;
        step();
        ins = 32'hFFFFFFFF;
        step();
        step();
        chk_state("mid_memrd", 4'd3);
        reset = 1'b0;
        #1;
        chk_state("mid_rst", 4'd0);
        chk_outs("mid_rst", 0, 6'd0, 6'd0);
        step();
        chk_state("mid_rst_hold", 4'd0);
        chk_outs("mid_rst_hold", 0, 6'd0, 6'd0);
        reset = 1'b1;
        run_instr(32'hFC000000, 0, 2, 24'h000010, "post_rst");

        // Random instructions against the model.
        for (int r = 0; r < 80; r++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                6: op = 6'b000101;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                4: fn = 6'h2A;
                default: fn = 6'($urandom);
            endcase
            mid = 20'($urandom);
            n = model_path(op, p);
            run_instr({op, mid, fn}, 2, n, p, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
